l2_miss_arbiter: RTL and testbench
==================================

// Module: l2_miss_arbiter
// PURPOSE
//  Shares the single L2/main-memory port of the 2-level cache controller between the L1 I-cache and L1 D-cache miss engines.
//  Round-robin arbitration, one outstanding transaction at a time; latches request, forwards to L2, returns data/ack to winner.
//  Timeout watchdog flags a hung L2. Sits between the L1 miss FSMs and the L2 controller, all in the cache-controller clock domain.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data word width
//  TIMEOUT  64   max cycles waiting for l2_ack before error; 0 disables watchdog
//  CNT_W    16   width of per-requester saturating grant counters
// PORTS
//  clk          in   1       cache-controller clock; all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  i_req        in   1       I-cache miss request; held with i_addr until i_ack
//  i_addr       in   ADDR_W  I-cache miss address (read only)
//  i_ack        out  1       one-cycle pulse: I transaction done
//  d_req        in   1       D-cache request; held with d_addr/d_we/d_wdata until d_ack
//  d_addr       in   ADDR_W  D-cache address
//  d_we         in   1       1 = write-back, 0 = read fill
//  d_wdata      in   DATA_W  write data
//  d_ack        out  1       one-cycle pulse: D transaction done
//  rsp_rdata    out  DATA_W  read data, valid while i_ack|d_ack
//  rsp_err      out  1       with ack: transaction timed out, rsp_rdata = 0
//  l2_req       out  1       request to L2, held until l2_ack
//  l2_addr      out  ADDR_W  latched address
//  l2_we        out  1       latched write enable (0 for I)
//  l2_wdata     out  DATA_W  latched write data (0 for I)
//  l2_ack       in   1       L2 completion, sampled only in BUSY
//  l2_rdata     in   DATA_W  L2 read data, valid with l2_ack
//  i_grants     out  CNT_W   saturating count of I grants
//  d_grants     out  CNT_W   saturating count of D grants
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, last_grant=I (D wins first tie), counters 0, watchdog 0.
//  - FSM states:
//    - IDLE -> BUSY when i_req|d_req.
//    - BUSY -> RESP on l2_ack, or on watchdog expiry.
//    - RESP -> IDLE unconditionally.
//  - IDLE: winner = only requester, else the one != last_grant. On the edge: latch addr/we/wdata and owner,
//    set l2_req=1, update last_grant, increment the owner's grant counter (saturate at all-ones).
//  - Latency: req seen at edge N -> l2_req high in cycle N+1. l2_ack sampled at edge M -> ack pulse in cycle M+1.
//    Minimum turnaround is 3 cycles (IDLE, BUSY, RESP).
//  - BUSY: l2_req/l2_addr/l2_we/l2_wdata held stable; watchdog increments each cycle.
//    If TIMEOUT!=0 and watchdog==TIMEOUT-1 with no l2_ack: drop l2_req, go RESP with rsp_err=1.
//    l2_ack on that same cycle wins, with no error.
//  - RESP: owner's ack=1 for exactly one cycle; rsp_rdata = latched l2_rdata (0 if err or write); l2_req=0; watchdog cleared.
//    A req still high during RESP is not re-granted; the requester must drop it at that edge.
//  - l2_ack outside BUSY is ignored. New requests arriving in BUSY/RESP wait; no request is ever dropped.
//  - Requests are level-held: the block never drops a held request, and round-robin guarantees no starvation.
//    Changing addr while req is high is a protocol error; behaviour is undefined but must not lock the FSM.
//  - Reset mid-transaction: abandon immediately (l2_req=0 next cycle, no ack issued), counters cleared.
// STRUCTURE
//  - Shared package cc_arb_pkg: state encoding (IDLE/BUSY/RESP), requester IDs (REQ_I=0, REQ_D=1), default TIMEOUT.
//  - One sub-module rr_picker2: 2-way round-robin pick from {req vector, last_grant} -> grant id, combinational.
//  - Everything else (FSM, latches, watchdog, counters) lives in l2_miss_arbiter.
// TESTING
//  1. Single I read: i_req=1, i_addr=0x0000_0040. L2 acks 2 cycles after l2_req with rdata=0xDEAD_BEEF
//     -> l2_addr=0x40, l2_we=0; i_ack one cycle with rsp_rdata=0xDEAD_BEEF; i_grants=1.
//  2. Simultaneous i_req and d_req after reset -> D granted first, then I; d_grants=1, i_grants=1; l2_req low for 2 cycles between.
//  3. Both requesters re-request continuously for 10 transactions -> grants strictly alternate D,I,D,I; no ack on the wrong port.
//  4. D write: d_we=1, d_addr=0x100, d_wdata=0x1234_5678
//     -> l2_we=1, l2_wdata=0x1234_5678 stable until l2_ack; d_ack with rsp_rdata=0, rsp_err=0.
//  5. Watchdog: TIMEOUT=8, L2 never acks -> l2_req drops after 8 BUSY cycles; ack with rsp_err=1; then a queued request proceeds.
//  6. rst=1 mid-BUSY -> next cycle l2_req=0, no ack pulse, counters 0; a stray l2_ack after reset is ignored.

Source files
------------

// File: rtl/cc_arb_pkg.sv
// cc_arb_pkg: shared types for the L2 miss arbiter.
//   state_t   - arbiter FSM states (IDLE/BUSY/RESP)
//   req_id_t  - requester identity (REQ_I = I-cache, REQ_D = D-cache)
//   DEFAULT_TIMEOUT - default L2 watchdog limit in cycles
package cc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/l2_miss_arbiter_if.sv
// l2_miss_arbiter_if: bundle of the L1 miss-engine and L2 controller handshakes.
//   I side : i_req, i_addr -> ; <- i_ack
//   D side : d_req, d_addr, d_we, d_wdata -> ; <- d_ack
//   Shared : <- rsp_rdata, rsp_err (valid with i_ack|d_ack)
//   L2 side: <- l2_req, l2_addr, l2_we, l2_wdata ; l2_ack, l2_rdata ->
// Modports: slave  = the arbiter itself
//           master = the environment (L1 miss FSMs plus L2 controller)
interface l2_miss_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              l2_req;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_we;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_ack;
    logic [DATA_W-1:0] l2_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, l2_ack, l2_rdata,
        output i_ack, d_ack, rsp_rdata, rsp_err, l2_req, l2_addr, l2_we, l2_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, l2_ack, l2_rdata,
        input  i_ack, d_ack, rsp_rdata, rsp_err, l2_req, l2_addr, l2_we, l2_wdata
    );
endinterface

// File: rtl/rr_picker2.sv
// rr_picker2: combinational 2-way round-robin picker.
//   req[0]     in  I-cache request
//   req[1]     in  D-cache request
//   last_grant in  requester granted most recently
//   grant      out chosen requester (meaningful only when req != 0)
// A lone requester always wins; on a tie the one that did not win last time wins.
module rr_picker2
    import cc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant
);
    always_comb begin
        grant = last_grant;
        case (req)
            2'b01:   grant = REQ_I;
            2'b10:   grant = REQ_D;
            2'b11:   grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
            default: grant = last_grant;
        endcase
    end
endmodule

// File: rtl/l2_miss_arbiter.sv
// l2_miss_arbiter: shares the single L2 port between the L1 I-cache and
// D-cache miss engines. Round-robin, one outstanding transaction, with an
// optional watchdog that completes a hung transaction with rsp_err.
//   clk      in   cache-controller clock, rising edge
//   rst      in   synchronous active-high reset
//   bus      slave modport of l2_miss_arbiter_if (L1 requests, L2 port, responses)
//   i_grants out  saturating count of I grants
//   d_grants out  saturating count of D grants
module l2_miss_arbiter
    import cc_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    l2_miss_arbiter_if.slave bus,
    output logic [CNT_W-1:0] i_grants,
    output logic [CNT_W-1:0] d_grants
);
    state_t      state;
    req_id_t     owner;
    req_id_t     last_grant;
    req_id_t     pick;
    logic [31:0] wd;

    rr_picker2 u_picker (
        .req        ({bus.d_req, bus.i_req}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= REQ_I;
            last_grant    <= REQ_I;
            wd            <= '0;
            bus.l2_req    <= 1'b0;
            bus.l2_addr   <= '0;
            bus.l2_we     <= 1'b0;
            bus.l2_wdata  <= '0;
            bus.i_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            i_grants      <= '0;
            d_grants      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state      <= ST_BUSY;
                        owner      <= pick;
                        last_grant <= pick;
                        wd         <= '0;
                        bus.l2_req <= 1'b1;
                        if (pick == REQ_D) begin
                            bus.l2_addr  <= bus.d_addr;
                            bus.l2_we    <= bus.d_we;
                            bus.l2_wdata <= bus.d_wdata;
                            if (d_grants != '1) d_grants <= d_grants + 1'b1;
                        end else begin
                            bus.l2_addr  <= bus.i_addr;
                            bus.l2_we    <= 1'b0;
                            bus.l2_wdata <= '0;
                            if (i_grants != '1) i_grants <= i_grants + 1'b1;
                        end
                    end
                end

                ST_BUSY: begin
                    // l2_ack takes priority over a watchdog expiry in the same cycle.
                    if (bus.l2_ack) begin
                        state         <= ST_RESP;
                        bus.l2_req    <= 1'b0;
                        bus.rsp_rdata <= bus.l2_we ? '0 : bus.l2_rdata;
                        bus.rsp_err   <= 1'b0;
                        if (owner == REQ_I) bus.i_ack <= 1'b1;
                        else                bus.d_ack <= 1'b1;
                    end else if (TIMEOUT != 0 && wd == 32'(TIMEOUT - 1)) begin
                        state         <= ST_RESP;
                        bus.l2_req    <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        if (owner == REQ_I) bus.i_ack <= 1'b1;
                        else                bus.d_ack <= 1'b1;
                    end else begin
                        wd <= wd + 32'd1;
                    end
                end

                ST_RESP: begin
                    // Requests seen here are deliberately not arbitrated; the
                    // acked requester drops its req at this edge.
                    state         <= ST_IDLE;
                    wd            <= '0;
                    bus.i_ack     <= 1'b0;
                    bus.d_ack     <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_miss_arbiter.sv
// tb_l2_miss_arbiter: directed self-checking bench for l2_miss_arbiter
// (TIMEOUT = 8). Inputs are driven and outputs sampled on the falling edge.
module tb_l2_miss_arbiter;
    logic        clk;
    logic        rst;
    logic [15:0] i_grants;
    logic [15:0] d_grants;
    int unsigned vectors;
    int unsigned errors;

    l2_miss_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    l2_miss_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8),
        .CNT_W   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .i_grants (i_grants),
        .d_grants (d_grants)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.d_req    = 1'b0;
        bus.d_addr   = '0;
        bus.d_we     = 1'b0;
        bus.d_wdata  = '0;
        bus.l2_ack   = 1'b0;
        bus.l2_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.l2_req !== 1'b0) begin errors++; $display("FAIL reset_l2_req got=%b exp=0", bus.l2_req); end
        vectors++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got=%b%b exp=00", bus.i_ack, bus.d_ack); end
        vectors++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.rsp_rdata, bus.rsp_err); end
        vectors++; if (i_grants !== 16'd0 || d_grants !== 16'd0) begin errors++; $display("FAIL reset_grants got=%0d/%0d exp=0/0", i_grants, d_grants); end
    endtask

    task automatic test_single_i();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0040;
        tick();
        vectors++; if (bus.l2_req !== 1'b1) begin errors++; $display("FAIL single_l2_req got=%b exp=1", bus.l2_req); end
        vectors++; if (bus.l2_addr !== 32'h40 || bus.l2_we !== 1'b0) begin errors++; $display("FAIL single_l2_addr got=%h/%b exp=00000040/0", bus.l2_addr, bus.l2_we); end
        vectors++; if (i_grants !== 16'd1) begin errors++; $display("FAIL single_i_grants got=%0d exp=1", i_grants); end
        tick();
        bus.l2_ack   = 1'b1;
        bus.l2_rdata = 32'hDEAD_BEEF;
        tick();
        bus.l2_ack = 1'b0;
        vectors++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL single_ack got=i%b d%b exp=i1 d0", bus.i_ack, bus.d_ack); end
        vectors++; if (bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_rdata got=%h/%b exp=deadbeef/0", bus.rsp_rdata, bus.rsp_err); end
        vectors++; if (bus.l2_req !== 1'b0) begin errors++; $display("FAIL single_l2_req_drop got=%b exp=0", bus.l2_req); end
        bus.i_req = 1'b0;
        tick();
        vectors++; if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got=%b exp=0", bus.i_ack); end
    endtask

    task automatic test_tie();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0300;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0200;
        tick();
        vectors++; if (bus.l2_addr !== 32'h200) begin errors++; $display("FAIL tie_first_addr got=%h exp=00000200", bus.l2_addr); end
        vectors++; if (d_grants !== 16'd1 || i_grants !== 16'd0) begin errors++; $display("FAIL tie_first_grants got=i%0d d%0d exp=i0 d1", i_grants, d_grants); end
        bus.l2_ack   = 1'b1;
        bus.l2_rdata = 32'h0000_0011;
        tick();
        bus.l2_ack = 1'b0;
        vectors++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.rsp_rdata !== 32'h11) begin errors++; $display("FAIL tie_d_ack got=d%b i%b %h exp=d1 i0 00000011", bus.d_ack, bus.i_ack, bus.rsp_rdata); end
        vectors++; if (bus.l2_req !== 1'b0) begin errors++; $display("FAIL tie_gap1 got=%b exp=0", bus.l2_req); end
        bus.d_req = 1'b0;
        tick();
        vectors++; if (bus.l2_req !== 1'b0) begin errors++; $display("FAIL tie_gap2 got=%b exp=0", bus.l2_req); end
        tick();
        vectors++; if (bus.l2_req !== 1'b1 || bus.l2_addr !== 32'h300) begin errors++; $display("FAIL tie_second got=%b/%h exp=1/00000300", bus.l2_req, bus.l2_addr); end
        vectors++; if (i_grants !== 16'd1 || d_grants !== 16'd1) begin errors++; $display("FAIL tie_second_grants got=i%0d d%0d exp=i1 d1", i_grants, d_grants); end
        bus.l2_ack = 1'b1;
        tick();
        bus.l2_ack = 1'b0;
        vectors++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL tie_i_ack got=i%b d%b exp=i1 d0", bus.i_ack, bus.d_ack); end
        bus.i_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        do_reset();
        exp_d = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.i_req  = 1'b1;
            bus.d_req  = 1'b1;
            bus.i_addr = 32'h0000_1000 + 32'(k);
            bus.d_addr = 32'h0000_2000 + 32'(k);
            tick();
            vectors++;
            if (bus.l2_addr !== (exp_d ? 32'h0000_2000 + 32'(k) : 32'h0000_1000 + 32'(k))) begin
                errors++; $display("FAIL b2b_addr txn=%0d got=%h exp_d=%b", k, bus.l2_addr, exp_d);
            end
            bus.l2_ack   = 1'b1;
            bus.l2_rdata = 32'(k);
            tick();
            bus.l2_ack = 1'b0;
            vectors++;
            if (bus.d_ack !== exp_d || bus.i_ack !== !exp_d) begin
                errors++; $display("FAIL b2b_ack txn=%0d got=d%b i%b exp=d%b i%b", k, bus.d_ack, bus.i_ack, exp_d, !exp_d);
            end
            if (exp_d) bus.d_req = 1'b0;
            else       bus.i_req = 1'b0;
            tick();
            exp_d = !exp_d;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        vectors++; if (i_grants !== 16'd5 || d_grants !== 16'd5) begin errors++; $display("FAIL b2b_grants got=i%0d d%0d exp=i5 d5", i_grants, d_grants); end
    endtask

    task automatic test_d_write();
        do_reset();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = 32'h1234_5678;
        tick();
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.l2_req !== 1'b1 || bus.l2_we !== 1'b1 || bus.l2_addr !== 32'h100 || bus.l2_wdata !== 32'h1234_5678) begin
                errors++; $display("FAIL wr_hold cyc=%0d got=%b/%b/%h/%h exp=1/1/00000100/12345678", c, bus.l2_req, bus.l2_we, bus.l2_addr, bus.l2_wdata);
            end
            if (c != 2) tick();
        end
        bus.l2_ack   = 1'b1;
        bus.l2_rdata = 32'hFFFF_FFFF;
        tick();
        bus.l2_ack = 1'b0;
        vectors++; if (bus.d_ack !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL wr_ack got=%b/%h/%b exp=1/00000000/0", bus.d_ack, bus.rsp_rdata, bus.rsp_err); end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int unsigned cnt;
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0080;
        tick();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.l2_req !== 1'b1) break;
            cnt++;
            if (c == 2) begin
                bus.d_req  = 1'b1;
                bus.d_addr = 32'h0000_0500;
            end
            tick();
        end
        vectors++; if (cnt != 8) begin errors++; $display("FAIL wd_busy_cycles got=%0d exp=8", cnt); end
        vectors++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL wd_ack got=i%b d%b exp=i1 d0", bus.i_ack, bus.d_ack); end
        vectors++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wd_err got=%b/%h exp=1/00000000", bus.rsp_err, bus.rsp_rdata); end
        bus.i_req = 1'b0;
        tick();
        tick();
        vectors++; if (bus.l2_req !== 1'b1 || bus.l2_addr !== 32'h500) begin errors++; $display("FAIL wd_queued got=%b/%h exp=1/00000500", bus.l2_req, bus.l2_addr); end
        bus.l2_ack   = 1'b1;
        bus.l2_rdata = 32'h0000_00AA;
        tick();
        bus.l2_ack = 1'b0;
        vectors++; if (bus.d_ack !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hAA) begin errors++; $display("FAIL wd_queued_ack got=%b/%b/%h exp=1/0/000000aa", bus.d_ack, bus.rsp_err, bus.rsp_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0044;
        tick();
        vectors++; if (bus.l2_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", bus.l2_req); end
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.i_req = 1'b0;
        vectors++; if (bus.l2_req !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("FAIL rstmid_abandon got=%b/%b/%b exp=0/0/0", bus.l2_req, bus.i_ack, bus.d_ack); end
        vectors++; if (i_grants !== 16'd0 || d_grants !== 16'd0) begin errors++; $display("FAIL rstmid_grants got=%0d/%0d exp=0/0", i_grants, d_grants); end
        bus.l2_ack   = 1'b1;
        bus.l2_rdata = 32'h5555_5555;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.l2_req !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
                errors++; $display("FAIL rstmid_stray cyc=%0d got=%b/%b/%b/%h exp=0/0/0/0", c, bus.i_ack, bus.d_ack, bus.l2_req, bus.rsp_rdata);
            end
        end
        bus.l2_ack = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_single_i();
        test_tie();
        test_back_to_back();
        test_d_write();
        test_watchdog();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
